// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Optional hit/miss/write counters are enabled with `define DCACHE_STATS_EN.
module dcache_wt #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int INDEX_BITS     = 6,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_writes
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - 4 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t state_q, state_d;
    logic [1:0] beat_q, beat_d;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES*WORDS_PER_LINE];

    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [1:0]            offset;
    logic [INDEX_BITS+1:0] word_idx;
    logic                  hit;
    logic                  refill_ack;
    logic                  store_ack;
    logic                  miss_start;
    logic                  unused_addr_lsb;

    logic                  arr_we;
    logic [INDEX_BITS+1:0] arr_widx;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] merged;

    assign tag             = req_addr[ADDR_WIDTH-1:4+INDEX_BITS];
    assign index           = req_addr[4+INDEX_BITS-1:4];
    assign offset          = req_addr[3:2];
    assign word_idx        = {index, offset};
    assign hit             = valid_q[index] && (tag_q[index] == tag);
    assign resp_rdata      = data_q[word_idx];
    assign unused_addr_lsb = ^req_addr[1:0];

    assign refill_ack = (state_q == REFILL) && mem_ack;
    assign store_ack  = (state_q == WRITE) && mem_ack;
    assign miss_start = (state_q == IDLE) && req_valid && !req_we && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'h0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_we) begin
                    stall   = 1'b1;
                    state_d = WRITE;
                end else if (miss_start) begin
                    stall   = 1'b1;
                    beat_d  = 2'd0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_be   = 4'hF;
                mem_addr = {req_addr[ADDR_WIDTH-1:4], beat_q, 2'b00};
                if (mem_ack) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = IDLE;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_be    = req_be;
                mem_wdata = req_wdata;
                if (mem_ack) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Valid is dropped on miss entry and set only by the final beat, so an
    // aborted refill never exposes a partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (miss_start) begin
            valid_q[index] <= 1'b0;
        end else if (refill_ack && beat_q == 2'd3) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (refill_ack && beat_q == 2'd3) tag_q[index] <= tag;
    end

    always_comb begin
        merged = data_q[word_idx];
        for (int b = 0; b < 4; b++) begin
            if (req_be[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
        end
    end

    always_comb begin
        arr_we    = 1'b0;
        arr_widx  = word_idx;
        arr_wdata = merged;
        if (refill_ack) begin
            arr_we    = 1'b1;
            arr_widx  = {index, beat_q};
            arr_wdata = mem_rdata;
        end else if (store_ack && hit) begin
            arr_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) data_q[arr_widx] <= arr_wdata;
    end

`ifdef DCACHE_STATS_EN
    logic hit_evt;
    assign hit_evt = (state_q == IDLE) && req_valid && !req_we && hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
            stat_writes <= 32'd0;
        end else begin
            if (hit_evt && stat_hits != 32'hFFFF_FFFF)       stat_hits   <= stat_hits + 32'd1;
            if (miss_start && stat_misses != 32'hFFFF_FFFF)  stat_misses <= stat_misses + 32'd1;
            if (store_ack && stat_writes != 32'hFFFF_FFFF)   stat_writes <= stat_writes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: vector table of CPU accesses against a
// behavioural main memory, plus hand sequences for spurious ack and mid-refill reset.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] resp_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        ack_r = 1'b0;
    logic        inject_ack = 1'b0;
    wire         mem_ack = ack_r | inject_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

    always #5 clk = ~clk;

    dcache_wt dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .resp_rdata(resp_rdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writes(stat_writes)
`endif
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Main memory: line 0x100 holds 0xA0..0xA3, everything else reads as 0xC000_0000|addr
    // until written.
    logic [31:0] mem_store [int unsigned];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        if (a[31:4] == 28'h10) return 32'hA0 + 32'(a[3:2]);
        return 32'hC000_0000 | a;
    endfunction

    int          n_reads = 0;
    int          n_writes = 0;
    int          unstable = 0;
    logic [31:0] rd_log [$];
    logic [31:0] last_waddr = 32'h0;
    logic [3:0]  last_wbe = 4'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        req_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;

    // Acks each request in the cycle after it is first presented (2 cycles per beat).
    initial begin
        logic [31:0] cur;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack_r    = 1'b0;
                req_prev = 1'b0;
            end else begin
                if (req_prev && !ack_r && (!mem_req || mem_addr != addr_prev)) unstable++;
                if (mem_req && req_prev && !ack_r) begin
                    ack_r = 1'b1;
                    if (mem_we) begin
                        cur = mem_read(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_store[mem_addr] = cur;
                        last_waddr = mem_addr;
                        last_wbe   = mem_be;
                        last_wdata = mem_wdata;
                        n_writes++;
                    end else begin
                        mem_rdata = mem_read(mem_addr);
                        rd_log.push_back(mem_addr);
                        n_reads++;
                    end
                end else begin
                    ack_r = 1'b0;
                end
                req_prev  = mem_req;
                addr_prev = mem_addr;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) assert (!(stall && !req_valid)) else $error("req_valid dropped while stalled");
    end

    // Called at posedge+2; returns after the access retires, again at posedge+2.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output int stalls, output int reads, output int writes);
        int r0, w0;
        r0 = n_reads;
        w0 = n_writes;
        stalls = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        @(negedge clk);
        while (stall && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        rdata = resp_rdata;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_we    = 1'b0;
        reads  = n_reads - r0;
        writes = n_writes - w0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          exp_reads;
        int          exp_writes;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        int st, nr, nw, guard, r0, exp_hits, exp_misses, exp_wr;

        // load miss: 1 lookup + 8 refill stall cycles; store: 1 lookup + 2 write cycles
        vecs[0]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_00A0, 9, 4, 0};
        vecs[1]  = '{1'b0, 32'h0000_0108, 4'h0, 32'h0,         32'h0000_00A2, 0, 0, 0};
        vecs[2]  = '{1'b1, 32'h0000_0104, 4'h3, 32'h0000_BEEF, 32'h0,         3, 0, 1};
        vecs[3]  = '{1'b0, 32'h0000_0104, 4'h0, 32'h0,         32'h0000_BEEF, 0, 0, 0};
        vecs[4]  = '{1'b1, 32'h0000_010C, 4'hC, 32'h5A5A_0000, 32'h0,         3, 0, 1};
        vecs[5]  = '{1'b0, 32'h0000_010C, 4'h0, 32'h0,         32'h5A5A_00A3, 0, 0, 0};
        vecs[6]  = '{1'b1, 32'h0000_2000, 4'hF, 32'h1234_5678, 32'h0,         3, 0, 1};
        vecs[7]  = '{1'b0, 32'h0000_2000, 4'h0, 32'h0,         32'h1234_5678, 9, 4, 0};
        vecs[8]  = '{1'b0, 32'h0000_0500, 4'h0, 32'h0,         32'hC000_0500, 9, 4, 0};
        vecs[9]  = '{1'b0, 32'h0000_0504, 4'h0, 32'h0,         32'hC000_0504, 0, 0, 0};
        vecs[10] = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_00A0, 9, 4, 0};
        vecs[11] = '{1'b0, 32'h0000_0104, 4'h0, 32'h0,         32'h0000_BEEF, 0, 0, 0};
        vecs[12] = '{1'b0, 32'h0000_010C, 4'h0, 32'h0,         32'h5A5A_00A3, 0, 0, 0};
        vecs[13] = '{1'b0, 32'h0000_2004, 4'h0, 32'h0,         32'hC000_2004, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_stall",     {31'h0, stall},   32'h0);
        check("rst_mem_req",   {31'h0, mem_req}, 32'h0);
        check("rst_mem_we",    {31'h0, mem_we},  32'h0);
        check("rst_mem_addr",  mem_addr,         32'h0);
        check("rst_mem_be",    {28'h0, mem_be},  32'h0);
        check("rst_mem_wdata", mem_wdata,        32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        exp_hits = 0; exp_misses = 0; exp_wr = 0;
        for (int i = 0; i < NV; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, st, nr, nw);
            if (!vecs[i].we) begin
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
                exp_hits++;
                if (vecs[i].exp_reads != 0) exp_misses++;
            end else begin
                check($sformatf("v%0d_waddr", i), last_waddr, {vecs[i].addr[31:2], 2'b00});
                check($sformatf("v%0d_wbe", i), {28'h0, last_wbe}, {28'h0, vecs[i].be});
                check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wdata);
                exp_wr++;
            end
            check($sformatf("v%0d_stall_cycles", i), st, vecs[i].exp_stall);
            check($sformatf("v%0d_mem_reads", i), nr, vecs[i].exp_reads);
            check($sformatf("v%0d_mem_writes", i), nw, vecs[i].exp_writes);
        end

        for (int i = 0; i < 4; i++)
            check($sformatf("cold_beat%0d_addr", i), rd_log[i], 32'h100 + 32'(4 * i));

        // Spurious ack while idle must be ignored.
        mem_rdata  = 32'hDEAD_BEEF;
        inject_ack = 1'b1;
        @(negedge clk);
        check("spur_stall",   {31'h0, stall},   32'h0);
        check("spur_mem_req", {31'h0, mem_req}, 32'h0);
        @(posedge clk);
        #2;
        inject_ack = 1'b0;
        access(1'b0, 32'h0000_0108, 4'h0, 32'h0, rd, st, nr, nw);
        exp_hits++;
        check("spur_load_rdata", rd, 32'h0000_00A2);
        check("spur_load_stall", st, 0);
        check("spur_load_reads", nr, 0);

`ifdef DCACHE_STATS_EN
        check("stat_hits",   stat_hits,   exp_hits);
        check("stat_misses", stat_misses, exp_misses);
        check("stat_writes", stat_writes, exp_wr);
`endif

        // Reset pulse after the third beat of a refill is accepted.
        r0 = n_reads;
        guard = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0300;
        while ((n_reads - r0) < 3 && guard < 100) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("abort_beats_before_reset", n_reads - r0, 3);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("abort_mem_req", {31'h0, mem_req}, 32'h0);
        check("abort_stall",   {31'h0, stall},   32'h0);
        check("abort_mem_addr", mem_addr,        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        access(1'b0, 32'h0000_0300, 4'h0, 32'h0, rd, st, nr, nw);
        check("reissue_rdata", rd, 32'hC000_0300);
        check("reissue_stall", st, 9);
        check("reissue_reads", nr, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("reissue_beat%0d_addr", i), rd_log[rd_log.size() - 4 + i],
                  32'h300 + 32'(4 * i));
        access(1'b0, 32'h0000_0108, 4'h0, 32'h0, rd, st, nr, nw);
        check("post_reset_miss_reads", nr, 4);
        check("post_reset_miss_rdata", rd, 32'h0000_00A2);

        check("mem_req_stability_violations", unstable, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
